// File: rtl/train_order_gen.sv
// train_order_gen: builds a stack-achievable car departure order from a
// push/pop op string and streams it in the sortability checker's protocol.
//
// Optional feature: define TRAIN_GEN_ERR_EN to add the err_inj input, which
// replaces the order with a non-achievable one (3,1,2,4..N) when N >= 3.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          request pulse, sampled only in IDLE
//   car_num        requested car count N (0 -> 1, >MAX_CARS -> MAX_CARS)
//   op_bits        op string, LSB first, 1 = push next car, 0 = pop
//   err_inj        (TRAIN_GEN_ERR_EN only) request a non-achievable order
//   busy           high in every state except IDLE
//   out_valid      stream valid (one count beat, then N order beats)
//   data           stream data, 0 whenever out_valid is low
//   expect_result  result the checker must return for the current train
//   done           one-cycle pulse after the last order beat
module train_order_gen #(
    parameter int MAX_CARS   = 10,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            car_num,
`ifdef TRAIN_GEN_ERR_EN
    input  logic                  err_inj,
`endif
    input  logic [2*MAX_CARS-1:0] op_bits,
    output logic                  busy,
    output logic                  out_valid,
    output logic [3:0]            data,
    output logic                  expect_result,
    output logic                  done
);

    localparam int CW = $clog2(2*MAX_CARS+1);
    localparam int IW = $clog2(MAX_CARS);
    localparam int OW = $clog2(2*MAX_CARS);
    localparam int GW = $clog2(GAP_CYCLES+2);

    localparam logic [3:0]    NMAX    = 4'(MAX_CARS);
    localparam logic [GW-1:0] GAP_END = GW'(GAP_CYCLES-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUILD,
        S_SEND_N,
        S_SEND_ORD,
        S_DONE,
        S_GAP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]            r_n;
    logic [2*MAX_CARS-1:0] r_ops;
    logic                  r_err;
    logic                  r_expect;
    logic [CW-1:0]         r_sp;
    logic [CW-1:0]         r_next;
    logic [CW-1:0]         r_ocnt;
    logic [OW-1:0]         r_opidx;
    logic [CW-1:0]         r_idx;
    logic [GW-1:0]         r_gap;
    logic [3:0]            r_stack [MAX_CARS];
    logic [3:0]            r_order [MAX_CARS];

    logic [3:0]    w_nclamp;
    logic          w_err_cap;
    logic [CW-1:0] w_n_ext;
    logic          w_op;
    logic          w_empty;
    logic          w_all_in;
    logic          w_push;
    logic [IW-1:0] w_top_idx;
    logic [3:0]    w_top;
    logic          w_build_last;
    logic          w_send_last;
    logic          w_gap_last;
    logic [3:0]    w_ord_data;

    assign w_nclamp = (car_num == 4'd0) ? 4'd1 :
                      (car_num > NMAX)  ? NMAX : car_num;

`ifdef TRAIN_GEN_ERR_EN
    assign w_err_cap = err_inj && (w_nclamp >= 4'd3);
`else
    assign w_err_cap = 1'b0;
`endif

    assign w_n_ext  = CW'(r_n);
    assign w_op     = r_ops[r_opidx];
    assign w_empty  = (r_sp == '0);
    assign w_all_in = (r_next > w_n_ext);

    // Illegal ops are legalised: pop on empty pushes, push past N pops.
    assign w_push    = w_empty || (w_op && !w_all_in);
    assign w_top_idx = r_sp[IW-1:0] - IW'(1);
    assign w_top     = r_stack[w_top_idx];

    // Exactly N pushes and N pops fit in 2N ops, so the last pop ends BUILD.
    assign w_build_last = !w_push && (r_ocnt + CW'(1) == w_n_ext);
    assign w_send_last  = (r_idx + CW'(1) == w_n_ext);
    assign w_gap_last   = (r_gap == GAP_END);

    always_comb begin
        w_ord_data = r_order[r_idx[IW-1:0]];
        if (r_err) begin
            unique case (1'b1)
                (r_idx == CW'(0)): w_ord_data = 4'd3;
                (r_idx == CW'(1)): w_ord_data = 4'd1;
                (r_idx == CW'(2)): w_ord_data = 4'd2;
                default:           w_ord_data = 4'(r_idx + CW'(1));
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_BUILD;
                end
            end
            S_BUILD: begin
                if (w_build_last) begin
                    w_next = S_SEND_N;
                end
            end
            S_SEND_N: begin
                w_next = S_SEND_ORD;
            end
            S_SEND_ORD: begin
                if (w_send_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (w_gap_last) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        out_valid = 1'b0;
        data      = 4'd0;
        done      = 1'b0;
        case (r_state)
            S_SEND_N: begin
                out_valid = 1'b1;
                data      = r_n;
            end
            S_SEND_ORD: begin
                out_valid = 1'b1;
                data      = w_ord_data;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign expect_result = r_expect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n      <= '0;
            r_ops    <= '0;
            r_err    <= 1'b0;
            r_expect <= 1'b0;
            r_sp     <= '0;
            r_next   <= '0;
            r_ocnt   <= '0;
            r_opidx  <= '0;
            r_idx    <= '0;
            r_gap    <= '0;
            for (int i = 0; i < MAX_CARS; i++) begin
                r_stack[i] <= '0;
                r_order[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n      <= w_nclamp;
                        r_ops    <= op_bits;
                        r_err    <= w_err_cap;
                        r_expect <= !w_err_cap;
                        r_sp     <= '0;
                        r_next   <= CW'(1);
                        r_ocnt   <= '0;
                        r_opidx  <= '0;
                        r_idx    <= '0;
                        r_gap    <= '0;
                    end
                end
                S_BUILD: begin
                    r_opidx <= r_opidx + OW'(1);
                    if (w_push) begin
                        r_stack[r_sp[IW-1:0]] <= r_next[3:0];
                        r_sp   <= r_sp + CW'(1);
                        r_next <= r_next + CW'(1);
                    end else begin
                        r_order[r_ocnt[IW-1:0]] <= w_top;
                        r_sp   <= r_sp - CW'(1);
                        r_ocnt <= r_ocnt + CW'(1);
                    end
                end
                S_SEND_ORD: begin
                    r_idx <= r_idx + CW'(1);
                end
                S_GAP: begin
                    r_gap <= r_gap + GW'(1);
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

endmodule
